mc_responder: RTL and testbench

- Behavioural memory-controller responder. It is the other end of the mc_rq/mc_rs interface that the PHOLD top level and the phold_core instances drive.
- It accepts read and write requests, performs them on an internal 64-bit word store, and returns in-order responses after a fixed pipeline latency.
- Responses pass through a bounded response FIFO. Back-pressure is applied through mc_rq_stall and honoured through mc_rs_stall.
- Used as the memory-side model in simulation and as the on-chip stand-in memory for standalone FPGA bring-up.

---
 rtl/mc_responder_if.sv | 52 +++++
 rtl/mc_responder.sv | 156 +++++++++++++++
 tb/tb_mc_responder.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_responder_if.sv
// ---------------------------------------------------------------------------
// mc_responder_if
//
// Purpose: groups the memory-controller request/response bus between a
// requester (PHOLD top level, phold_core or a testbench) and the
// mc_responder memory model.
//
// Signals:
//   mc_rq_vld/cmd/scmd/vadr/size/rtnctl/data/flush  request, requester -> responder
//   mc_rq_stall                                     request back-pressure, responder -> requester
//   mc_rs_vld/cmd/scmd/rtnctl/data                  response, responder -> requester
//   mc_rs_stall                                     response back-pressure, requester -> responder
//   err                                             sticky protocol error, responder -> requester
//
// Modports: master = requester side, slave = responder side.
// ---------------------------------------------------------------------------
interface mc_responder_if #(
  parameter int MC_RTNCTL_WIDTH = 32
);
  logic                       mc_rq_vld;
  logic [2:0]                 mc_rq_cmd;
  logic [3:0]                 mc_rq_scmd;
  logic [47:0]                mc_rq_vadr;
  logic [1:0]                 mc_rq_size;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rq_rtnctl;
  logic [63:0]                mc_rq_data;
  logic                       mc_rq_flush;
  logic                       mc_rq_stall;

  logic                       mc_rs_vld;
  logic [2:0]                 mc_rs_cmd;
  logic [3:0]                 mc_rs_scmd;
  logic [MC_RTNCTL_WIDTH-1:0] mc_rs_rtnctl;
  logic [63:0]                mc_rs_data;
  logic                       mc_rs_stall;

  logic                       err;

  modport master (
    output mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
           mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    input  mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
           mc_rs_data, err
  );

  modport slave (
    input  mc_rq_vld, mc_rq_cmd, mc_rq_scmd, mc_rq_vadr, mc_rq_size,
           mc_rq_rtnctl, mc_rq_data, mc_rq_flush, mc_rs_stall,
    output mc_rq_stall, mc_rs_vld, mc_rs_cmd, mc_rs_scmd, mc_rs_rtnctl,
           mc_rs_data, err
  );
endinterface

// File: rtl/mc_responder.sv
// ---------------------------------------------------------------------------
// mc_responder
//
// Purpose: behavioural memory-controller responder. Accepts 8-byte read and
// write requests, performs them on an internal 64-bit word store and returns
// in-order responses after a fixed pipeline latency through a bounded
// response FIFO. Credit accounting (pipeline + FIFO occupancy) drives the
// request back-pressure, so the latency pipeline itself never stalls.
//
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   mc     mc_responder_if.slave: request bus in, response bus out,
//          mc_rq_stall / mc_rs_stall back-pressure, sticky err
// ---------------------------------------------------------------------------
module mc_responder #(
  parameter int MC_RTNCTL_WIDTH = 32,
  parameter int NB_MEM_ADDR     = 6,
  parameter int LATENCY         = 3,
  parameter int FIFO_DEPTH      = 8
) (
  input logic           clk,
  input logic           rst_n,
  mc_responder_if.slave mc
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  // Wide enough for inflight (<= LATENCY) plus FIFO count (<= FIFO_DEPTH).
  localparam int SW = $clog2(FIFO_DEPTH + LATENCY + 1);
  localparam int MW = 2 ** NB_MEM_ADDR;

  typedef struct packed {
    logic [2:0]                 cmd;
    logic [MC_RTNCTL_WIDTH-1:0] rtnctl;
    logic [63:0]                data;
  } resp_t;

  logic [63:0]            r_mem [MW];
  logic                   r_pvld [LATENCY];
  resp_t                  r_pipe [LATENCY];
  resp_t                  r_fifo [FIFO_DEPTH];
  logic [PW-1:0]          r_wptr;
  logic [PW-1:0]          r_rptr;
  logic [CW-1:0]          r_cnt;
  logic                   r_err;

  logic                   w_accept;
  logic                   w_legal;
  logic                   w_isWrite;
  logic [NB_MEM_ADDR-1:0] w_idx;
  logic [SW-1:0]          w_inflight;
  logic [SW-1:0]          w_credit;
  logic                   w_stall;
  logic                   w_push;
  logic                   w_pop;
  logic                   w_empty;
  resp_t                  w_head;
  logic                   w_unused;

  assign w_legal   = ((mc.mc_rq_cmd == 3'd1) || (mc.mc_rq_cmd == 3'd2)) &&
                     (mc.mc_rq_size == 2'd3);
  assign w_isWrite = (mc.mc_rq_cmd == 3'd2);
  assign w_idx     = mc.mc_rq_vadr[3 +: NB_MEM_ADDR];
  assign w_accept  = mc.mc_rq_vld && !w_stall;

  // Sub-command, flush and address bits outside the word index carry no
  // meaning for this model.
  assign w_unused = ^{mc.mc_rq_scmd, mc.mc_rq_flush,
                      mc.mc_rq_vadr[47:3+NB_MEM_ADDR], mc.mc_rq_vadr[2:0]};

  // Count of valid pipeline stages; each one holds a reserved FIFO slot.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_pvld[i]);
    end
  end

  assign w_credit = w_inflight + SW'(r_cnt);
  assign w_stall  = (w_credit >= SW'(FIFO_DEPTH));

  // Word store: written at the acceptance edge, deliberately not reset so
  // contents survive a reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_legal && w_isWrite) begin
      r_mem[w_idx] <= mc.mc_rq_data;
    end
  end

  // Latency shift register. Read data is captured at acceptance, so a read
  // right after a write to the same word sees the new value. Illegal
  // requests enter with valid low and therefore never reach the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        r_pvld[i] <= 1'b0;
        r_pipe[i] <= '0;
      end
    end else begin
      r_pvld[0]        <= w_accept && w_legal;
      r_pipe[0].cmd    <= w_isWrite ? 3'd3 : 3'd2;
      r_pipe[0].rtnctl <= mc.mc_rq_rtnctl;
      r_pipe[0].data   <= w_isWrite ? 64'd0 : r_mem[w_idx];
      for (int i = 1; i < LATENCY; i++) begin
        r_pvld[i] <= r_pvld[i-1];
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign w_push  = r_pvld[LATENCY-1];
  assign w_empty = (r_cnt == '0);
  assign w_pop   = !w_empty && !mc.mc_rs_stall;
  assign w_head  = r_fifo[r_rptr];

  // Response FIFO. Credit accounting guarantees a push never hits a full
  // FIFO; storage is cleared on reset so the head reads as zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo[i] <= '0;
      end
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wptr] <= r_pipe[LATENCY-1];
        r_wptr         <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  // Sticky error: illegal command/size, or a request dropped by back-pressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if ((mc.mc_rq_vld && w_stall) || (w_accept && !w_legal)) begin
      r_err <= 1'b1;
    end
  end

  assign mc.mc_rq_stall  = w_stall;
  assign mc.mc_rs_vld    = w_pop;
  assign mc.mc_rs_cmd    = w_head.cmd;
  assign mc.mc_rs_scmd   = 4'd0;
  assign mc.mc_rs_rtnctl = w_head.rtnctl;
  assign mc.mc_rs_data   = w_head.data;
  assign mc.err          = r_err;

endmodule

// File: tb/tb_mc_responder.sv
// ---------------------------------------------------------------------------
// tb_mc_responder
//
// Purpose: directed self-checking bench for mc_responder with default
// parameters (LATENCY=3, FIFO_DEPTH=8, 64-word store, 32-bit rtnctl).
// Inputs are driven 1 time unit after each rising edge and checked 1 unit
// later; a negedge monitor logs every response that leaves the FIFO.
// ---------------------------------------------------------------------------
module tb_mc_responder;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   vldUnderStall = 0;

  int          logCyc[$];
  logic [2:0]  logCmd[$];
  logic [31:0] logRtn[$];
  logic [63:0] logData[$];

  localparam logic [63:0] DATA_A = 64'hDEADBEEF00000001;
  localparam logic [63:0] DATA_B = 64'h0123456789ABCDEF;

  mc_responder_if #(.MC_RTNCTL_WIDTH(32)) mc ();

  mc_responder #(
    .MC_RTNCTL_WIDTH(32),
    .NB_MEM_ADDR    (6),
    .LATENCY        (3),
    .FIFO_DEPTH     (8)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .mc   (mc)
  );

  // Free-running clock and cycle counter.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Response monitor: each negedge with rs_vld high is one popped response.
  always @(negedge clk) begin
    if (mc.mc_rs_vld) begin
      logCyc.push_back(cyc);
      logCmd.push_back(mc.mc_rs_cmd);
      logRtn.push_back(mc.mc_rs_rtnctl);
      logData.push_back(mc.mc_rs_data);
    end
    if (mc.mc_rs_vld && mc.mc_rs_stall) vldUnderStall++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs,
                             input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of request inputs; returns with inputs settled.
  task automatic applyStimulus(input logic vld, input logic [2:0] cmd,
                               input logic [47:0] vadr, input logic [1:0] size,
                               input logic [31:0] rtnctl, input logic [63:0] data,
                               input logic rsStall);
    @(posedge clk);
    #1;
    mc.mc_rq_vld    = vld;
    mc.mc_rq_cmd    = cmd;
    mc.mc_rq_vadr   = vadr;
    mc.mc_rq_size   = size;
    mc.mc_rq_rtnctl = rtnctl;
    mc.mc_rq_data   = data;
    mc.mc_rs_stall  = rsStall;
    #1;
  endtask

  task automatic idle(input int n, input logic rsStall);
    repeat (n) applyStimulus(1'b0, 3'd0, 48'd0, 2'd0, 32'd0, 64'd0, rsStall);
  endtask

  task automatic waitLog(input int n, input int budget, input string tag);
    int k = 0;
    while (logCmd.size() < n && k < budget) begin
      idle(1, 1'b0);
      k++;
    end
    checkOutput(tag, 64'(logCmd.size()), 64'(n));
  endtask

  task automatic clearLog();
    logCyc.delete();
    logCmd.delete();
    logRtn.delete();
    logData.delete();
  endtask

  initial begin
    int wc;
    int start;
    int rel;
    int rc;

    mc.mc_rq_vld    = 1'b0;
    mc.mc_rq_cmd    = 3'd0;
    mc.mc_rq_scmd   = 4'd0;
    mc.mc_rq_vadr   = 48'd0;
    mc.mc_rq_size   = 2'd0;
    mc.mc_rq_rtnctl = 32'd0;
    mc.mc_rq_data   = 64'd0;
    mc.mc_rq_flush  = 1'b0;
    mc.mc_rs_stall  = 1'b0;

    // Reset values
    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_rq_stall", 64'(mc.mc_rq_stall), 64'd0);
    checkOutput("rst_rs_vld",   64'(mc.mc_rs_vld),   64'd0);
    checkOutput("rst_rs_cmd",   64'(mc.mc_rs_cmd),   64'd0);
    checkOutput("rst_rs_scmd",  64'(mc.mc_rs_scmd),  64'd0);
    checkOutput("rst_rs_rtn",   64'(mc.mc_rs_rtnctl), 64'd0);
    checkOutput("rst_rs_data",  mc.mc_rs_data,       64'd0);
    checkOutput("rst_err",      64'(mc.err),         64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Write word 3 then read it back the next cycle
    $display("[TB] write then read");
    applyStimulus(1'b1, 3'd2, 48'h18, 2'd3, 32'd5, DATA_A, 1'b0);
    wc = cyc;
    applyStimulus(1'b1, 3'd1, 48'h18, 2'd3, 32'd6, 64'd0, 1'b0);
    idle(1, 1'b0);
    waitLog(2, 12, "wr_rd_count");
    checkOutput("wr_rs_cmd",  64'(logCmd[0]), 64'd3);
    checkOutput("wr_rs_rtn",  64'(logRtn[0]), 64'd5);
    checkOutput("wr_rs_data", logData[0],     64'd0);
    checkOutput("wr_rs_cyc",  64'(logCyc[0] - wc), 64'd4);
    checkOutput("rd_rs_cmd",  64'(logCmd[1]), 64'd2);
    checkOutput("rd_rs_rtn",  64'(logRtn[1]), 64'd6);
    checkOutput("rd_rs_data", logData[1],     DATA_A);
    checkOutput("rd_rs_cyc",  64'(logCyc[1] - wc), 64'd5);

    // 20 back-to-back reads at full throughput
    $display("[TB] back-to-back reads");
    clearLog();
    start = 0;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1, 3'd1, 48'h18, 2'd3, 32'(i), 64'd0, 1'b0);
      if (i == 0) start = cyc;
      checkOutput("b2b_rq_stall", 64'(mc.mc_rq_stall), 64'd0);
    end
    idle(1, 1'b0);
    waitLog(20, 40, "b2b_count");
    for (int i = 0; i < 20; i++) begin
      checkOutput("b2b_rtn",  64'(logRtn[i]),  64'(i));
      checkOutput("b2b_data", logData[i],      DATA_A);
      checkOutput("b2b_cyc",  64'(logCyc[i]),  64'(start + 4 + i));
    end
    checkOutput("b2b_err", 64'(mc.err), 64'd0);

    // Credit limit: responses held off, requests offered every cycle
    $display("[TB] credit limit");
    clearLog();
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, 3'd1, 48'h18, 2'd3, 32'(100 + i), 64'd0, 1'b1);
      checkOutput("credit_rq_stall", 64'(mc.mc_rq_stall), (i >= 8) ? 64'd1 : 64'd0);
    end
    idle(4, 1'b1);
    checkOutput("credit_full_stall", 64'(mc.mc_rq_stall), 64'd1);
    checkOutput("credit_no_rs",      64'(logCmd.size()),  64'd0);
    checkOutput("credit_err",        64'(mc.err),         64'd1);
    idle(1, 1'b0);
    rel = cyc;
    checkOutput("drain_rs_vld",   64'(mc.mc_rs_vld),   64'd1);
    checkOutput("drain_stall_0",  64'(mc.mc_rq_stall), 64'd1);
    idle(1, 1'b0);
    checkOutput("drain_stall_1",  64'(mc.mc_rq_stall), 64'd0);
    waitLog(8, 20, "drain_count");
    for (int i = 0; i < 8; i++) begin
      checkOutput("drain_rtn", 64'(logRtn[i]), 64'(100 + i));
      checkOutput("drain_cyc", 64'(logCyc[i]), 64'(rel + i));
    end
    idle(4, 1'b0);
    checkOutput("drain_final_count", 64'(logCmd.size()), 64'd8);

    // Response back-pressure toggling every cycle
    $display("[TB] toggling rs_stall");
    clearLog();
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, 3'd1, 48'h18, 2'd3, 32'(200 + i), 64'd0, 1'(i % 2));
      checkOutput("toggle_rq_stall", 64'(mc.mc_rq_stall), 64'd0);
    end
    for (int j = 10; j < 50 && logCmd.size() < 10; j++) begin
      applyStimulus(1'b0, 3'd0, 48'd0, 2'd0, 32'd0, 64'd0, 1'(j % 2));
    end
    idle(6, 1'b0);
    checkOutput("toggle_count", 64'(logCmd.size()), 64'd10);
    for (int i = 0; i < 10; i++) begin
      checkOutput("toggle_rtn", 64'(logRtn[i]), 64'(200 + i));
    end
    checkOutput("vld_under_stall", 64'(vldUnderStall), 64'd0);

    // Reset with 3 requests in the pipeline and 2 in the FIFO
    $display("[TB] reset mid-operation");
    applyStimulus(1'b1, 3'd2, 48'h38, 2'd3, 32'd50, DATA_B, 1'b0);
    idle(6, 1'b0);
    clearLog();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 3'd1, 48'h18, 2'd3, 32'(300 + i), 64'd0, 1'b1);
    end
    idle(1, 1'b0);
    checkOutput("pre_rst_rs_vld", 64'(mc.mc_rs_vld),    64'd1);
    checkOutput("pre_rst_rs_rtn", 64'(mc.mc_rs_rtnctl), 64'd300);
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_rs_vld",   64'(mc.mc_rs_vld),    64'd0);
    checkOutput("mid_rst_rq_stall", 64'(mc.mc_rq_stall),  64'd0);
    checkOutput("mid_rst_err",      64'(mc.err),          64'd0);
    checkOutput("mid_rst_rs_cmd",   64'(mc.mc_rs_cmd),    64'd0);
    checkOutput("mid_rst_rs_rtn",   64'(mc.mc_rs_rtnctl), 64'd0);
    checkOutput("mid_rst_rs_data",  mc.mc_rs_data,        64'd0);
    clearLog();
    idle(2, 1'b0);
    rst_n = 1'b1;
    idle(6, 1'b0);
    checkOutput("post_rst_no_stale", 64'(logCmd.size()), 64'd0);
    applyStimulus(1'b1, 3'd1, 48'h38, 2'd3, 32'd399, 64'd0, 1'b0);
    rc = cyc;
    idle(10, 1'b0);
    checkOutput("post_rst_count", 64'(logCmd.size()), 64'd1);
    checkOutput("post_rst_rtn",   64'(logRtn[0]),     64'd399);
    checkOutput("post_rst_data",  logData[0],         DATA_B);
    checkOutput("post_rst_cyc",   64'(logCyc[0]),     64'(rc + 4));
    checkOutput("post_rst_err",   64'(mc.err),        64'd0);

    // Illegal command, illegal size and flush produce no response
    $display("[TB] illegal requests");
    clearLog();
    applyStimulus(1'b1, 3'd5, 48'h38, 2'd3, 32'd500, 64'd0, 1'b0);
    checkOutput("ill_err_before", 64'(mc.err), 64'd0);
    applyStimulus(1'b1, 3'd1, 48'h38, 2'd2, 32'd502, 64'd0, 1'b0);
    checkOutput("ill_err_set", 64'(mc.err), 64'd1);
    applyStimulus(1'b1, 3'd1, 48'h38, 2'd3, 32'd501, 64'd0, 1'b0);
    rc = cyc;
    idle(1, 1'b0);
    mc.mc_rq_flush = 1'b1;
    idle(1, 1'b0);
    mc.mc_rq_flush = 1'b0;
    idle(8, 1'b0);
    checkOutput("ill_count",    64'(logCmd.size()), 64'd1);
    checkOutput("ill_rtn",      64'(logRtn[0]),     64'd501);
    checkOutput("ill_data",     logData[0],         DATA_B);
    checkOutput("ill_cyc",      64'(logCyc[0]),     64'(rc + 4));
    checkOutput("ill_err_kept", 64'(mc.err),        64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
